// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter.
//   src_t       : which requester issued an access
//   tag_t       : one in-flight read-tag slot {vld, src}
//   MEM_LAT_MAX : deepest supported memory read latency
//   killFetch() : clears a tag's valid bit when it belongs to fetch and kill is set
package arb_pkg;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_DM = 1'b1
  } src_t;

  typedef struct packed {
    logic vld;
    src_t src;
  } tag_t;

  localparam int unsigned MEM_LAT_MAX = 4;

  function automatic tag_t killFetch(input tag_t t, input logic kill);
    tag_t r;
    r = t;
    if (kill && (t.src == SRC_IF)) begin
      r.vld = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the arbiter and the
// memory macro.
//   if_req_* / if_rsp_*  : fetch request handshake and read response
//   dm_req_* / dm_rsp_*  : data request handshake (read/write) and read response
//   mem_*                : single-ported pipelined memory access port
// Modports:
//   slave  : the arbiter's view (accepts requests, drives the memory port)
//   master : the surrounding pipeline + memory macro view
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic            if_req_valid;
  logic            if_req_ready;
  logic [AW-1:0]   if_req_addr;
  logic            if_rsp_valid;
  logic [DW-1:0]   if_rsp_data;

  logic            dm_req_valid;
  logic            dm_req_ready;
  logic            dm_req_we;
  logic [AW-1:0]   dm_req_addr;
  logic [DW-1:0]   dm_req_wdata;
  logic [DW/8-1:0] dm_req_strb;
  logic            dm_rsp_valid;
  logic [DW-1:0]   dm_rsp_data;

  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_strb;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_strb,
    output dm_req_ready, dm_rsp_valid, dm_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_strb,
    input  mem_rdata
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata, dm_req_strb,
    input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_strb,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// arb_tag_pipe: MEM_LAT-deep shift register of read tags that lines up with
// the memory's read pipeline, so the tail tag describes the mem_rdata
// currently presented.
//   clk, rst : clock, synchronous active-low reset (clears every tag)
//   push     : a read was accepted this cycle (vld of the new stage-0 tag)
//   pushSrc  : requester of that read
//   killIf   : branch flush; drops every fetch tag already in the pipe,
//              including the tail seen this same cycle
//   tail     : oldest tag, already filtered by killIf
module arb_tag_pipe
  import arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  src_t pushSrc,
  input  logic killIf,
  output tag_t tail
);

  tag_t stages [MEM_LAT];

  // Stage 0 takes the new tag unfiltered: a fetch accepted in the flush cycle
  // belongs to the redirected stream and must survive. Older stages are
  // filtered as they shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < MEM_LAT; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= '{vld: push, src: pushSrc};
      for (int unsigned i = 1; i < MEM_LAT; i++) begin
        stages[i] <= killFetch(stages[i-1], killIf);
      end
    end
  end

  always_comb begin
    tail = killFetch(stages[MEM_LAT-1], killIf);
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined single-ported memory between the fetch
// stage and the memory stage. Data requests win over fetch; every read is
// tagged and its response is routed back to the issuer after MEM_LAT cycles.
// A branch flush drops fetch responses still in flight.
// Ports:
//   clk   : clock
//   rst   : synchronous reset, active-low
//   flush : branch redirect, kills in-flight fetch responses
//   bus   : mem_arbiter_if.slave (fetch/data request+response, memory port)
// Parameters: AW, DW, MEM_LAT (1..MEM_LAT_MAX), STARVE_MAX.
// Optional feature: define ARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_MAX consecutive fetch denials; otherwise data priority is strict.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  mem_arbiter_if.slave bus
);

  if ((MEM_LAT < 1) || (MEM_LAT > MEM_LAT_MAX) || (STARVE_MAX < 1)) begin : gBadParam
    $error("mem_arbiter: MEM_LAT must be 1..%0d and STARVE_MAX >= 1", MEM_LAT_MAX);
  end

  logic forceIf;
  logic dmReady;
  logic ifReady;
  logic dmXfer;
  logic ifXfer;
  logic readPush;
  src_t pushSrc;
  tag_t tail;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starveCnt;

  // Counts consecutive cycles a pending fetch was refused; saturates naturally
  // because reaching STARVE_MAX forces the grant that clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starveCnt <= '0;
    end else if (ifXfer) begin
      starveCnt <= '0;
    end else if (bus.if_req_valid && !ifReady) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  always_comb begin
    forceIf = (starveCnt == CW'(STARVE_MAX));
  end
`else
  always_comb begin
    forceIf = 1'b0;
  end
`endif

  // Grant: the two transfers are mutually exclusive by construction, since
  // fetch is only ready when data is idle or data has been blocked by forceIf.
  always_comb begin
    dmReady = rst & ~forceIf;
    ifReady = rst & (~bus.dm_req_valid | forceIf);
    dmXfer  = bus.dm_req_valid & dmReady;
    ifXfer  = bus.if_req_valid & ifReady;
  end

  always_comb begin
    bus.dm_req_ready = dmReady;
    bus.if_req_ready = ifReady;

    bus.mem_en    = dmXfer | ifXfer;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_strb  = '0;
    readPush      = 1'b0;
    pushSrc       = SRC_IF;

    if (dmXfer) begin
      bus.mem_we    = bus.dm_req_we;
      bus.mem_addr  = bus.dm_req_addr;
      bus.mem_wdata = bus.dm_req_wdata;
      bus.mem_strb  = bus.dm_req_we ? bus.dm_req_strb : '0;
      readPush      = ~bus.dm_req_we;
      pushSrc       = SRC_DM;
    end else if (ifXfer) begin
      bus.mem_addr  = bus.if_req_addr;
      readPush      = 1'b1;
      pushSrc       = SRC_IF;
    end
  end

  arb_tag_pipe #(
    .MEM_LAT(MEM_LAT)
  ) uTagPipe (
    .clk    (clk),
    .rst    (rst),
    .push   (readPush),
    .pushSrc(pushSrc),
    .killIf (flush),
    .tail   (tail)
  );

  // Responses are gated by rst so nothing is reported during the reset cycle
  // itself, before the tag registers have been cleared.
  always_comb begin
    bus.if_rsp_valid = rst & tail.vld & (tail.src == SRC_IF);
    bus.dm_rsp_valid = rst & tail.vld & (tail.src == SRC_DM);
    bus.if_rsp_data  = bus.mem_rdata;
    bus.dm_rsp_data  = bus.mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1 (b1/u1) and one
// with MEM_LAT=2 (b2/u2), sharing a small behavioural memory.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) b1 ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) b2 ();

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b1.slave)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b2.slave)
  );

  // Behavioural memory: 256 words, byte-strobed writes, 1- and 2-cycle read pipes.
  logic [31:0] mem [256];
  logic [31:0] rd1;
  logic [31:0] rd2a;
  logic [31:0] rd2b;

  function automatic logic [31:0] strbMask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we)
      mem[b1.mem_addr[9:2]] <= (mem[b1.mem_addr[9:2]] & ~strbMask(b1.mem_strb)) |
                               (b1.mem_wdata & strbMask(b1.mem_strb));
    if (b2.mem_en && b2.mem_we)
      mem[b2.mem_addr[9:2]] <= (mem[b2.mem_addr[9:2]] & ~strbMask(b2.mem_strb)) |
                               (b2.mem_wdata & strbMask(b2.mem_strb));
    rd1  <= mem[b1.mem_addr[9:2]];
    rd2a <= mem[b2.mem_addr[9:2]];
    rd2b <= rd2a;
  end

  assign b1.mem_rdata = rd1;
  assign b2.mem_rdata = rd2b;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleAll();
    b1.if_req_valid = 1'b0; b1.if_req_addr = '0;
    b1.dm_req_valid = 1'b0; b1.dm_req_we = 1'b0; b1.dm_req_addr = '0;
    b1.dm_req_wdata = '0;   b1.dm_req_strb = '0;
    b2.if_req_valid = 1'b0; b2.if_req_addr = '0;
    b2.dm_req_valid = 1'b0; b2.dm_req_we = 1'b0; b2.dm_req_addr = '0;
    b2.dm_req_wdata = '0;   b2.dm_req_strb = '0;
    flush = 1'b0;
  endtask

  task automatic applyReset();
    nextCycle();
    idleAll();
    rst = 1'b0;
    nextCycle();
    rst = 1'b1;
  endtask

  // Preload one word through u1's data port (no checks here).
  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    nextCycle();
    idleAll();
    b1.dm_req_valid = 1'b1; b1.dm_req_we = 1'b1;
    b1.dm_req_addr = a; b1.dm_req_wdata = d; b1.dm_req_strb = 4'hF;
  endtask

  task automatic test_reset();
    idleAll();
    rst = 1'b0;
    b1.dm_req_valid = 1'b1; b1.dm_req_addr = 32'h40;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h44;
    @(negedge clk);
    checks++; if (b1.dm_req_ready !== 1'b0) begin errors++; $display("FAIL rst_dm_ready got %b exp 0", b1.dm_req_ready); end
    checks++; if (b1.if_req_ready !== 1'b0) begin errors++; $display("FAIL rst_if_ready got %b exp 0", b1.if_req_ready); end
    checks++; if (b1.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", b1.mem_en); end
    checks++; if (b1.if_rsp_valid !== 1'b0 || b1.dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp got %b%b exp 00", b1.if_rsp_valid, b1.dm_rsp_valid); end
    nextCycle();
    idleAll();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b1.mem_en !== 1'b0 || b1.mem_we !== 1'b0 || b1.mem_strb !== 4'h0) begin errors++; $display("FAIL idle_mem got en=%b we=%b strb=%h exp 0 0 0", b1.mem_en, b1.mem_we, b1.mem_strb); end
    checks++; if (b1.dm_req_ready !== 1'b1 || b1.if_req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b%b exp 11", b1.dm_req_ready, b1.if_req_ready); end
  endtask

  task automatic test_write_read();
    nextCycle();
    idleAll();
    b1.dm_req_valid = 1'b1; b1.dm_req_we = 1'b1; b1.dm_req_addr = 32'h200;
    b1.dm_req_wdata = 32'h12345678; b1.dm_req_strb = 4'hF;
    @(negedge clk);
    checks++; if (b1.mem_en !== 1'b1 || b1.mem_we !== 1'b1) begin errors++; $display("FAIL wr_en_we got %b%b exp 11", b1.mem_en, b1.mem_we); end
    checks++; if (b1.mem_strb !== 4'hF) begin errors++; $display("FAIL wr_strb got %h exp f", b1.mem_strb); end
    checks++; if (b1.mem_addr !== 32'h200 || b1.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_addr_data got %h %h exp 200 12345678", b1.mem_addr, b1.mem_wdata); end
    nextCycle();
    b1.dm_req_we = 1'b0; b1.dm_req_wdata = '0; b1.dm_req_strb = '0;
    @(negedge clk);
    checks++; if (b1.mem_we !== 1'b0) begin errors++; $display("FAIL rd_we got %b exp 0", b1.mem_we); end
    checks++; if (b1.dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp got %b exp 0", b1.dm_rsp_valid); end
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++; if (b1.dm_rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %b exp 1", b1.dm_rsp_valid); end
    checks++; if (b1.dm_rsp_data !== 32'h12345678) begin errors++; $display("FAIL rd_rsp_data got %h exp 12345678", b1.dm_rsp_data); end
    checks++; if (b1.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_if_quiet got %b exp 0", b1.if_rsp_valid); end
  endtask

  task automatic test_fetch_basic();
    nextCycle();
    idleAll();
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h100;
    @(negedge clk);
    checks++; if (b1.if_req_ready !== 1'b1 || b1.mem_en !== 1'b1 || b1.mem_we !== 1'b0) begin errors++; $display("FAIL f_grant got rdy=%b en=%b we=%b exp 1 1 0", b1.if_req_ready, b1.mem_en, b1.mem_we); end
    checks++; if (b1.mem_addr !== 32'h100) begin errors++; $display("FAIL f_addr got %h exp 100", b1.mem_addr); end
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++; if (b1.if_rsp_valid !== 1'b1) begin errors++; $display("FAIL f_rsp_valid got %b exp 1", b1.if_rsp_valid); end
    checks++; if (b1.if_rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL f_rsp_data got %h exp deadbeef", b1.if_rsp_data); end
    checks++; if (b1.dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL f_dm_quiet got %b exp 0", b1.dm_rsp_valid); end
    nextCycle();
    @(negedge clk);
    checks++; if (b1.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL f_rsp_once got %b exp 0", b1.if_rsp_valid); end
  endtask

  task automatic test_priority();
    nextCycle();
    idleAll();
    b1.dm_req_valid = 1'b1; b1.dm_req_addr = 32'h200;
    b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h104;
    @(negedge clk);
    checks++; if (b1.dm_req_ready !== 1'b1 || b1.if_req_ready !== 1'b0) begin errors++; $display("FAIL p_ready got dm=%b if=%b exp 1 0", b1.dm_req_ready, b1.if_req_ready); end
    checks++; if (b1.mem_addr !== 32'h200) begin errors++; $display("FAIL p_addr0 got %h exp 200", b1.mem_addr); end
    nextCycle();
    b1.dm_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (b1.if_req_ready !== 1'b1 || b1.mem_addr !== 32'h104) begin errors++; $display("FAIL p_if_grant got rdy=%b addr=%h exp 1 104", b1.if_req_ready, b1.mem_addr); end
    checks++; if (b1.dm_rsp_valid !== 1'b1 || b1.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL p_rsp1_route got dm=%b if=%b exp 1 0", b1.dm_rsp_valid, b1.if_rsp_valid); end
    checks++; if (b1.dm_rsp_data !== 32'h12345678) begin errors++; $display("FAIL p_rsp1_data got %h exp 12345678", b1.dm_rsp_data); end
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++; if (b1.if_rsp_valid !== 1'b1 || b1.dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL p_rsp2_route got if=%b dm=%b exp 1 0", b1.if_rsp_valid, b1.dm_rsp_valid); end
    checks++; if (b1.if_rsp_data !== 32'h11112222) begin errors++; $display("FAIL p_rsp2_data got %h exp 11112222", b1.if_rsp_data); end
  endtask

  task automatic test_flush();
    nextCycle();
    idleAll();
    b2.if_req_valid = 1'b1; b2.if_req_addr = 32'h300;
    @(negedge clk);
    checks++; if (b2.if_req_ready !== 1'b1) begin errors++; $display("FAIL fl_t0_ready got %b exp 1", b2.if_req_ready); end
    nextCycle();
    b2.if_req_addr = 32'h304;
    flush = 1'b1;
    @(negedge clk);
    checks++; if (b2.if_req_ready !== 1'b1 || b2.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_t1 got rdy=%b rsp=%b exp 1 0", b2.if_req_ready, b2.if_rsp_valid); end
    nextCycle();
    idleAll();
    @(negedge clk);
    checks++; if (b2.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_killed got %b exp 0", b2.if_rsp_valid); end
    nextCycle();
    @(negedge clk);
    checks++; if (b2.if_rsp_valid !== 1'b1 || b2.if_rsp_data !== 32'hBBBB0002) begin errors++; $display("FAIL fl_survivor got v=%b d=%h exp 1 bbbb0002", b2.if_rsp_valid, b2.if_rsp_data); end
    // data reads in flight are not affected by flush
    nextCycle();
    b2.dm_req_valid = 1'b1; b2.dm_req_addr = 32'h200;
    nextCycle();
    idleAll();
    flush = 1'b1;
    @(negedge clk);
    checks++; if (b2.dm_rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_dm_early got %b exp 0", b2.dm_rsp_valid); end
    nextCycle();
    flush = 1'b0;
    @(negedge clk);
    checks++; if (b2.dm_rsp_valid !== 1'b1 || b2.dm_rsp_data !== 32'h12345678) begin errors++; $display("FAIL fl_dm_kept got v=%b d=%h exp 1 12345678", b2.dm_rsp_valid, b2.dm_rsp_data); end
  endtask

  task automatic test_starve();
    logic expDm;
    logic expIf;
    int unsigned lastK;
    applyReset();
`ifdef ARB_STARVE_GUARD_EN
    lastK = 6;
`else
    lastK = 8;
`endif
    for (int unsigned k = 1; k <= lastK; k++) begin
      nextCycle();
      b1.dm_req_valid = 1'b1; b1.dm_req_we = 1'b0; b1.dm_req_addr = 32'h200;
      b1.if_req_valid = 1'b1; b1.if_req_addr = 32'h100;
      expDm = 1'b1;
      expIf = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      if (k == 5) begin
        expDm = 1'b0;
        expIf = 1'b1;
      end
`endif
      @(negedge clk);
      checks++; if (b1.dm_req_ready !== expDm || b1.if_req_ready !== expIf) begin errors++; $display("FAIL starve_k%0d got dm=%b if=%b exp %b %b", k, b1.dm_req_ready, b1.if_req_ready, expDm, expIf); end
      checks++; if (b1.mem_addr !== (expIf ? 32'h100 : 32'h200)) begin errors++; $display("FAIL starve_addr_k%0d got %h exp %h", k, b1.mem_addr, expIf ? 32'h100 : 32'h200); end
    end
    nextCycle();
    idleAll();
    nextCycle();
    nextCycle();
  endtask

  task automatic test_reset_midflight();
    nextCycle();
    idleAll();
    b2.dm_req_valid = 1'b1; b2.dm_req_addr = 32'h200;
    @(negedge clk);
    checks++; if (b2.dm_req_ready !== 1'b1) begin errors++; $display("FAIL rm_accept got %b exp 1", b2.dm_req_ready); end
    nextCycle();
    rst = 1'b0;
    b2.if_req_valid = 1'b1; b2.if_req_addr = 32'h300;
    @(negedge clk);
    checks++; if (b2.dm_req_ready !== 1'b0 || b2.if_req_ready !== 1'b0) begin errors++; $display("FAIL rm_ready got dm=%b if=%b exp 0 0", b2.dm_req_ready, b2.if_req_ready); end
    checks++; if (b2.mem_en !== 1'b0) begin errors++; $display("FAIL rm_mem_en got %b exp 0", b2.mem_en); end
    nextCycle();
    idleAll();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (b2.dm_rsp_valid !== 1'b0 || b2.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_discard got dm=%b if=%b exp 0 0", b2.dm_rsp_valid, b2.if_rsp_valid); end
    nextCycle();
    @(negedge clk);
    checks++; if (b2.dm_rsp_valid !== 1'b0 || b2.if_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_replay got dm=%b if=%b exp 0 0", b2.dm_rsp_valid, b2.if_rsp_valid); end
  endtask

  initial begin
    test_reset();
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h104, 32'h11112222);
    preload(32'h300, 32'hAAAA0001);
    preload(32'h304, 32'hBBBB0002);
    test_write_read();
    test_fetch_basic();
    test_priority();
    test_flush();
    test_starve();
    test_reset_midflight();
    nextCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
